piradip_spi_csel_sequencer: RTL and testbench
=============================================

Name: piradip_spi_csel_sequencer

Overview:
- Synchronous chip-select sequencer that sits directly upstream of the board-level '139/'138 address decoders and '125 lane buffers in the SPI test harness.
- Accepts a per-transaction target index and drives the decoder address lines and active-low enable with programmable setup, lead, lag and gap timing.
- Enables the lane buffers and hands off to the SPI shift engine via a start/done handshake.
- Guarantees the decoder output settles before any select asserts and that only one target is ever selected.

Parameters:
- SEL_W, 3, width of decoder address (cs_addr).
- NUM_TARGETS, 8, number of valid target indices; must satisfy NUM_TARGETS <= 2**SEL_W.
- SETUP_CYC, 2, cycles address is stable with enable deasserted before select asserts (>=1).
- LEAD_CYC, 2, cycles select is asserted before xfer_start (>=1).
- LAG_CYC, 2, cycles select stays asserted after xfer_done (>=1).
- GAP_CYC, 4, minimum deselected cycles before the next request is accepted (>=1).
- TIMEOUT_CYC, 1024, maximum cycles spent in ACTIVE waiting for xfer_done.
- CNT_W, 16, phase/timeout counter width; must hold max(all *_CYC).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  transaction request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_sel  in  SEL_W  target index, sampled at acceptance
- xfer_start  out  1  one-cycle pulse to the SPI engine
- xfer_done  in  1  one-cycle pulse from the SPI engine
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  2  0=OK, 1=BAD_SEL, 2=TIMEOUT; valid with rsp_valid, held until next rsp_valid
- cs_addr  out  SEL_W  decoder address (A/B/C)
- cs_en_n  out  1  decoder enable, active-low (drives G2A)
- buf_oen  out  4  lane buffer output enables, active-low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sampled at posedge clk while rst=1): state=IDLE, cs_en_n=1, buf_oen=4'hF, cs_addr=0, req_ready=0, xfer_start=0, rsp_valid=0, rsp_status=0, busy=0. req_ready rises the first cycle after rst deasserts.
- Reset mid-transaction: same values on the next edge. No rsp_valid is issued. The select drops immediately.
- States: IDLE, SETUP, LEAD, ACTIVE, LAG, GAP. All outputs are registered.
- IDLE: req_ready=1.
  - On acceptance with req_sel < NUM_TARGETS: latch cs_addr and go to SETUP. cs_en_n stays 1.
  - On acceptance with req_sel >= NUM_TARGETS: cs_addr is unchanged, rsp_valid=1 and rsp_status=1 on the next cycle, and the state remains IDLE. req_ready is 0 during that response cycle.
- SETUP: exactly SETUP_CYC cycles with cs_en_n=1 and cs_addr stable, then LEAD.
- LEAD: cs_en_n=0 and buf_oen=4'h0 from the first LEAD cycle. Lasts exactly LEAD_CYC cycles, then ACTIVE.
- ACTIVE:
  - xfer_start=1 during the first ACTIVE cycle only.
  - Timeout counter starts at 0 on entry.
  - If xfer_done is seen: status=OK, go to LAG.
  - If the counter reaches TIMEOUT_CYC without xfer_done: status=TIMEOUT, go to LAG.
  - If xfer_done and timeout expiry occur in the same cycle, done wins (OK).
- xfer_done outside ACTIVE is ignored.
- LAG: exactly LAG_CYC cycles with cs_en_n=0.
- LAG->GAP transition: cs_en_n=1, buf_oen=4'hF, rsp_valid=1 for one cycle with the latched status.
- GAP: GAP_CYC cycles. cs_addr is held at its last value; it changes only on the next acceptance. Then IDLE.
- cs_addr never changes while cs_en_n=0. cs_en_n and buf_oen always change on the same edge.
- Parameters below their minimum cause an elaboration error via an initial check.

Decomposition:
- Package piradip_spi_csel_pkg holds:
  - state enum csel_state_t (IDLE..GAP);
  - status localparams CSEL_OK, CSEL_BAD_SEL, CSEL_TIMEOUT;
  - lane-enable constants BUF_ALL_OFF=4'hF, BUF_ALL_ON=4'h0.
- One sub-module, piradip_spi_csel_timer: loadable CNT_W down-counter with a zero flag. It is reused for the SETUP, LEAD, LAG and GAP phases and the ACTIVE timeout.

Test Plan:
- Reset, then req_sel=5 with defaults and xfer_done 10 cycles after xfer_start.
  - cs_addr=5 one cycle after acceptance; cs_en_n falls 2 cycles later; xfer_start 2 cycles after that.
  - cs_en_n rises 2 cycles after done, with rsp_valid/status=0 on that edge; req_ready returns 4 cycles later.
- NUM_TARGETS=6, req_sel=7: no cs_en_n activity and no xfer_start; rsp_valid with status=1 the next cycle; back-to-back request accepted the cycle after.
- TIMEOUT_CYC=16, xfer_done never arrives: rsp_status=2 after 16 ACTIVE cycles plus LAG_CYC; cs_en_n and buf_oen deassert cleanly.
- xfer_done on exactly the timeout-expiry cycle -> status=0. A stray xfer_done pulse in IDLE or LAG -> no state change.
- rst asserted during ACTIVE -> next edge cs_en_n=1, buf_oen=F, no rsp_valid; a new request completes normally.
- Random back-to-back requests: assertion checks that cs_addr is stable whenever cs_en_n=0 and that deselected time is >=GAP_CYC between selects.

Source files
------------

// File: rtl/piradip_spi_csel_pkg.sv
// Shared types and constants for the SPI chip-select sequencer.
package piradip_spi_csel_pkg;

    localparam int unsigned STATUS_W = 2;
    localparam int unsigned LANE_W   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        LEAD   = 3'd2,
        ACTIVE = 3'd3,
        LAG    = 3'd4,
        GAP    = 3'd5
    } csel_state_t;

    localparam logic [STATUS_W-1:0] CSEL_OK      = 2'd0;
    localparam logic [STATUS_W-1:0] CSEL_BAD_SEL = 2'd1;
    localparam logic [STATUS_W-1:0] CSEL_TIMEOUT = 2'd2;

    localparam logic [LANE_W-1:0] BUF_ALL_OFF = 4'hF;
    localparam logic [LANE_W-1:0] BUF_ALL_ON  = 4'h0;

    // True when a phase of 'cyc' cycles can be loaded as cyc-1 into a w-bit counter.
    function automatic logic cyc_fits(input int unsigned cyc, input int unsigned w);
        if (w >= 32) begin
            return 1'b1;
        end
        return ((cyc - 1) >> w) == 0;
    endfunction

endpackage

// File: rtl/piradip_spi_csel_sequencer_if.sv
// Request/response, SPI-engine handshake and decoder/buffer drive signals.
interface piradip_spi_csel_sequencer_if #(
    parameter int unsigned SEL_W = 3
);
    import piradip_spi_csel_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [SEL_W-1:0]    req_sel;
    logic                xfer_start;
    logic                xfer_done;
    logic                rsp_valid;
    logic [STATUS_W-1:0] rsp_status;
    logic [SEL_W-1:0]    cs_addr;
    logic                cs_en_n;
    logic [LANE_W-1:0]   buf_oen;
    logic                busy;

    // Sequencer side.
    modport slave (
        input  req_valid, req_sel, xfer_done,
        output req_ready, xfer_start, rsp_valid, rsp_status,
               cs_addr, cs_en_n, buf_oen, busy
    );

    // Requester / SPI engine / board side.
    modport master (
        output req_valid, req_sel, xfer_done,
        input  req_ready, xfer_start, rsp_valid, rsp_status,
               cs_addr, cs_en_n, buf_oen, busy
    );

endinterface

// File: rtl/piradip_spi_csel_timer.sv
// Loadable down-counter with a zero flag, shared by all timed phases.
module piradip_spi_csel_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/piradip_spi_csel_sequencer.sv
// Chip-select sequencer driving '139/'138 decoder address/enable and '125 lane buffers.
module piradip_spi_csel_sequencer
    import piradip_spi_csel_pkg::*;
#(
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned NUM_TARGETS = 8,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned LEAD_CYC    = 2,
    parameter int unsigned LAG_CYC     = 2,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    piradip_spi_csel_sequencer_if.slave bus
);

    localparam logic [SEL_W:0] NUM_TGT = (SEL_W+1)'(NUM_TARGETS);

    // Elaboration-time parameter sanity.
    if (SETUP_CYC == 0 || LEAD_CYC == 0 || LAG_CYC == 0 || GAP_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_cyc
        $error("piradip_spi_csel_sequencer: all *_CYC parameters must be >= 1");
    end
    if (NUM_TARGETS == 0 || NUM_TARGETS > (2 ** SEL_W)) begin : g_bad_targets
        $error("piradip_spi_csel_sequencer: NUM_TARGETS must be in 1..2**SEL_W");
    end
    if (!cyc_fits(SETUP_CYC, CNT_W) || !cyc_fits(LEAD_CYC, CNT_W) || !cyc_fits(LAG_CYC, CNT_W) ||
        !cyc_fits(GAP_CYC, CNT_W) || !cyc_fits(TIMEOUT_CYC, CNT_W)) begin : g_bad_cnt_w
        $error("piradip_spi_csel_sequencer: CNT_W too narrow for the phase lengths");
    end

    csel_state_t         state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                xfer_start_q, xfer_start_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [STATUS_W-1:0] rsp_status_q, rsp_status_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [SEL_W-1:0]    cs_addr_q, cs_addr_d;
    logic                cs_en_n_q, cs_en_n_d;
    logic [LANE_W-1:0]   buf_oen_q, buf_oen_d;
    logic                busy_q, busy_d;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_zero_c;
    logic                accept_c;
    logic                sel_ok_c;

    assign accept_c = (state_q == IDLE) && req_ready_q && bus.req_valid;
    assign sel_ok_c = ({1'b0, bus.req_sel} < NUM_TGT);

    piradip_spi_csel_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            xfer_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= CSEL_OK;
            status_q     <= CSEL_OK;
            cs_addr_q    <= '0;
            cs_en_n_q    <= 1'b1;
            buf_oen_q    <= BUF_ALL_OFF;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            xfer_start_q <= xfer_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            status_q     <= status_d;
            cs_addr_q    <= cs_addr_d;
            cs_en_n_q    <= cs_en_n_d;
            buf_oen_q    <= buf_oen_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output decode; select and lane buffers always move together.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        xfer_start_d = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        status_d     = status_q;
        cs_addr_d    = cs_addr_q;
        cs_en_n_d    = cs_en_n_q;
        buf_oen_d    = buf_oen_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept_c) begin
                    req_ready_d = 1'b0;
                    if (sel_ok_c) begin
                        state_d   = SETUP;
                        cs_addr_d = bus.req_sel;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = CSEL_BAD_SEL;
                    end
                end
            end
            SETUP: begin
                if (tmr_zero_c) begin
                    state_d   = LEAD;
                    cs_en_n_d = 1'b0;
                    buf_oen_d = BUF_ALL_ON;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(LEAD_CYC - 1);
                end
            end
            LEAD: begin
                if (tmr_zero_c) begin
                    state_d      = ACTIVE;
                    xfer_start_d = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = CNT_W'(TIMEOUT_CYC - 1);
                end
            end
            ACTIVE: begin
                // Done takes priority over a coincident timeout.
                if (bus.xfer_done) begin
                    state_d  = LAG;
                    status_d = CSEL_OK;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(LAG_CYC - 1);
                end else if (tmr_zero_c) begin
                    state_d  = LAG;
                    status_d = CSEL_TIMEOUT;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(LAG_CYC - 1);
                end
            end
            LAG: begin
                if (tmr_zero_c) begin
                    state_d      = GAP;
                    cs_en_n_d    = 1'b1;
                    buf_oen_d    = BUF_ALL_OFF;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = status_q;
                    tmr_load     = 1'b1;
                    tmr_val      = CNT_W'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (tmr_zero_c) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cs_en_n_d = 1'b1;
                buf_oen_d = BUF_ALL_OFF;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.xfer_start = xfer_start_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.cs_addr    = cs_addr_q;
    assign bus.cs_en_n    = cs_en_n_q;
    assign bus.buf_oen    = buf_oen_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_piradip_spi_csel_sequencer.sv
// Bench for the chip-select sequencer: timeline model plus directed literal checks.
module tb_piradip_spi_csel_sequencer;

    localparam int unsigned SEL_W = 3;
    localparam int NT    = 6;
    localparam int SETUP = 2;
    localparam int LEAD  = 2;
    localparam int LAG   = 2;
    localparam int GAP   = 4;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst;
    logic dir_done;
    logic eng_done;
    bit   eng_auto;

    always #5 clk = ~clk;

    piradip_spi_csel_sequencer_if #(.SEL_W(SEL_W)) bus ();

    assign bus.xfer_done = dir_done | eng_done;

    piradip_spi_csel_sequencer #(
        .SEL_W       (SEL_W),
        .NUM_TARGETS (NT),
        .SETUP_CYC   (SETUP),
        .LEAD_CYC    (LEAD),
        .LAG_CYC     (LAG),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Timeline model: each transaction is described by its acceptance edge,
    // start edge and end-of-ACTIVE edge; outputs follow from edge arithmetic.
    int cyc = 0;
    bit model_ok = 0;
    bit in_txn = 0;
    bit resolved = 0;
    int a_e = 0, s_e = 0, e_e = 0, bad_e = -100, st = 0;
    int e_ready = 0, e_start = 0, e_rspv = 0, e_status = 0;
    int e_addr = 0, e_en_n = 1, e_buf = 15, e_busy = 0;

    initial begin
        forever begin
            bit acc;
            @(posedge clk);
            cyc++;
            if (rst) begin
                model_ok = 1;
                in_txn   = 0;
                resolved = 0;
                bad_e    = -100;
                e_ready  = 0; e_start = 0; e_rspv = 0; e_status = 0;
                e_addr   = 0; e_en_n = 1; e_buf = 15; e_busy = 0;
            end else begin
                acc = bus.req_valid && (e_ready != 0);
                if (in_txn && !resolved && cyc > s_e) begin
                    if (bus.xfer_done) begin
                        resolved = 1; e_e = cyc; st = 0;
                    end else if (cyc == s_e + TMO) begin
                        resolved = 1; e_e = cyc; st = 2;
                    end
                end
                if (acc) begin
                    if (int'(bus.req_sel) < NT) begin
                        in_txn   = 1;
                        resolved = 0;
                        a_e      = cyc;
                        s_e      = cyc + SETUP + LEAD;
                        e_addr   = int'(bus.req_sel);
                    end else begin
                        bad_e = cyc;
                    end
                end
                if (in_txn && resolved && cyc == e_e + LAG + GAP) in_txn = 0;
                e_busy  = in_txn ? 1 : 0;
                e_en_n  = (in_txn && cyc >= a_e + SETUP && !(resolved && cyc >= e_e + LAG)) ? 0 : 1;
                e_buf   = (e_en_n != 0) ? 15 : 0;
                e_start = (in_txn && cyc == s_e) ? 1 : 0;
                e_rspv  = 0;
                if (bad_e == cyc) begin
                    e_rspv = 1; e_status = 1;
                end else if (in_txn && resolved && cyc == e_e + LAG) begin
                    e_rspv = 1; e_status = st;
                end
                e_ready = (!in_txn && !acc) ? 1 : 0;
            end
        end
    end

    // Auto-responding SPI engine for the random phase (done after 1..20 cycles).
    initial begin
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_auto && bus.xfer_start) begin
                int k;
                k = $urandom_range(1, 20);
                repeat (k - 1) @(negedge clk);
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    logic [SEL_W-1:0] prev_addr = '0;
    logic             prev_en_n = 1'b1;
    int               desel_run = 0;
    bit               had_sel = 0;

    // Per-cycle comparison against the model and select-safety invariants.
    task automatic compare_all();
        if (!model_ok) return;
        cmp("req_ready",  int'(bus.req_ready),  e_ready);
        cmp("xfer_start", int'(bus.xfer_start), e_start);
        cmp("rsp_valid",  int'(bus.rsp_valid),  e_rspv);
        cmp("rsp_status", int'(bus.rsp_status), e_status);
        cmp("cs_addr",    int'(bus.cs_addr),    e_addr);
        cmp("cs_en_n",    int'(bus.cs_en_n),    e_en_n);
        cmp("buf_oen",    int'(bus.buf_oen),    e_buf);
        cmp("busy",       int'(bus.busy),       e_busy);
        if (!prev_en_n && !bus.cs_en_n)
            cmp("addr_stable", int'(bus.cs_addr), int'(prev_addr));
        if (rst) begin
            had_sel   = 0;
            desel_run = 0;
        end else if (bus.cs_en_n) begin
            desel_run++;
        end else if (prev_en_n) begin
            if (had_sel) cmp("gap_ok", int'(desel_run >= GAP), 1);
            had_sel   = 1;
            desel_run = 0;
        end
        prev_addr = bus.cs_addr;
        prev_en_n = bus.cs_en_n;
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input int sel);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_sel   = SEL_W'(sel);
        while (!bus.req_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) cmp("send_wait", 0, 1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.xfer_start && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) cmp("start_wait", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!bus.req_ready && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) cmp("idle_wait", 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        dir_done      = 1'b0;
        eng_auto      = 0;
        bus.req_valid = 1'b0;
        bus.req_sel   = '0;
        repeat (3) step();
        cmp("rst_ready",   int'(bus.req_ready), 0);
        cmp("rst_en_n",    int'(bus.cs_en_n),   1);
        cmp("rst_buf",     int'(bus.buf_oen),   15);
        cmp("rst_busy",    int'(bus.busy),      0);
        rst = 1'b0;
        step();
        cmp("ready_after_rst", int'(bus.req_ready), 1);

        // Nominal transaction to target 5, done 10 cycles after start.
        send(5);
        cmp("t1_addr", int'(bus.cs_addr), 5);
        cmp("t1_en_n_setup", int'(bus.cs_en_n), 1);
        repeat (2) step();
        cmp("t1_en_n_fall", int'(bus.cs_en_n), 0);
        cmp("t1_buf_on", int'(bus.buf_oen), 0);
        repeat (2) step();
        cmp("t1_start", int'(bus.xfer_start), 1);
        repeat (9) step();
        dir_done = 1'b1;
        step();
        dir_done = 1'b0;
        cmp("t1_lag0_en_n", int'(bus.cs_en_n), 0);
        step();
        cmp("t1_lag1_en_n", int'(bus.cs_en_n), 0);
        cmp("t1_lag1_rspv", int'(bus.rsp_valid), 0);
        step();
        cmp("t1_rise_en_n", int'(bus.cs_en_n), 1);
        cmp("t1_rspv", int'(bus.rsp_valid), 1);
        cmp("t1_status", int'(bus.rsp_status), 0);
        cmp("t1_buf_off", int'(bus.buf_oen), 15);
        repeat (3) step();
        cmp("t1_gap_ready", int'(bus.req_ready), 0);
        step();
        cmp("t1_ready_back", int'(bus.req_ready), 1);

        // Out-of-range target, then a back-to-back valid request.
        send(7);
        cmp("bad_rspv", int'(bus.rsp_valid), 1);
        cmp("bad_status", int'(bus.rsp_status), 1);
        cmp("bad_ready", int'(bus.req_ready), 0);
        cmp("bad_addr_kept", int'(bus.cs_addr), 5);
        cmp("bad_en_n", int'(bus.cs_en_n), 1);
        send(2);
        cmp("b2b_addr", int'(bus.cs_addr), 2);
        cmp("b2b_busy", int'(bus.busy), 1);
        wait_start();
        dir_done = 1'b1;
        step();
        dir_done = 1'b0;
        wait_idle(100);

        // Timeout with no done.
        send(3);
        wait_start();
        repeat (16) step();
        cmp("tmo_lag_en_n", int'(bus.cs_en_n), 0);
        cmp("tmo_lag_rspv", int'(bus.rsp_valid), 0);
        step();
        cmp("tmo_lag1_en_n", int'(bus.cs_en_n), 0);
        step();
        cmp("tmo_rspv", int'(bus.rsp_valid), 1);
        cmp("tmo_status", int'(bus.rsp_status), 2);
        cmp("tmo_en_n", int'(bus.cs_en_n), 1);
        cmp("tmo_buf", int'(bus.buf_oen), 15);
        wait_idle(100);

        // Done on the expiry cycle, held into LAG as a stray pulse.
        send(4);
        wait_start();
        repeat (15) step();
        dir_done = 1'b1;
        step();
        step();
        dir_done = 1'b0;
        step();
        cmp("race_rspv", int'(bus.rsp_valid), 1);
        cmp("race_status", int'(bus.rsp_status), 0);
        wait_idle(100);
        dir_done = 1'b1;
        step();
        dir_done = 1'b0;
        step();
        cmp("stray_idle_busy", int'(bus.busy), 0);
        cmp("stray_idle_ready", int'(bus.req_ready), 1);

        // Reset in ACTIVE, then a clean transaction.
        send(1);
        wait_start();
        repeat (3) step();
        rst = 1'b1;
        step();
        cmp("mrst_en_n", int'(bus.cs_en_n), 1);
        cmp("mrst_buf", int'(bus.buf_oen), 15);
        cmp("mrst_rspv", int'(bus.rsp_valid), 0);
        cmp("mrst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        step();
        cmp("mrst_ready", int'(bus.req_ready), 1);
        send(0);
        wait_start();
        dir_done = 1'b1;
        step();
        dir_done = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.rsp_valid && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) cmp("post_rst_rsp_wait", 0, 1);
        end
        cmp("post_rst_status", int'(bus.rsp_status), 0);
        wait_idle(100);

        // Random back-to-back requests with an auto-responding engine.
        eng_auto = 1;
        for (int i = 0; i < 24; i++) begin
            send(int'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle(300);
        eng_auto = 0;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
